// File: rtl/alu_uart_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_uart_ctrl_if
// Brief    : UART RX/TX, ALU and status bundle for the ALU frame sequencer.
// Revision : 1.0
// ============================================================================
interface alu_uart_ctrl_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_done;
  logic [NB_DATA-1:0] i_alu_result;
  logic               i_tx_done;
  logic [NB_OP-1:0]   o_alu_op;
  logic [NB_DATA-1:0] o_alu_data_A;
  logic [NB_DATA-1:0] o_alu_data_B;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_tx_start;
  logic               o_busy;
  logic               o_frame_err;
  logic               o_drop;

  // Sequencer side
  modport master (
    input  i_rx_data, i_rx_done, i_alu_result, i_tx_done,
    output o_alu_op, o_alu_data_A, o_alu_data_B, o_tx_data,
    output o_tx_start, o_busy, o_frame_err, o_drop
  );

  // UART / ALU side
  modport slave (
    output i_rx_data, i_rx_done, i_alu_result, i_tx_done,
    input  o_alu_op, o_alu_data_A, o_alu_data_B, o_tx_data,
    input  o_tx_start, o_busy, o_frame_err, o_drop
  );
endinterface
`default_nettype wire

// File: rtl/alu_uart_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_uart_ctrl
// Brief    : Collects A/B/opcode frames from UART RX, runs the ALU, sends result.
// Revision : 1.0
// ============================================================================
module alu_uart_ctrl #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic           i_clk,
  input  logic           i_reset,
  alu_uart_ctrl_if.master bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    WAIT_TX = 3'd4
  } state_e;

  state_e             state_q,     state_d;
  logic [NB_OP-1:0]   alu_op_q,    alu_op_d;
  logic [NB_DATA-1:0] alu_a_q,     alu_a_d;
  logic [NB_DATA-1:0] alu_b_q,     alu_b_d;
  logic [NB_DATA-1:0] tx_data_q,   tx_data_d;
  logic               tx_start_q,  tx_start_d;
  logic               busy_q,      busy_d;
  logic               frame_err_q, frame_err_d;
  logic               drop_q,      drop_d;
  logic [CNT_W-1:0]   tmo_cnt_q,   tmo_cnt_d;

  logic [NB_OP-1:0]   op_field;
  logic               op_valid;
  logic               tmo_hit;

  assign op_field = bus.i_rx_data[NB_OP-1:0];

  always_comb begin
    op_valid = 1'b0;
    case (op_field)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL: op_valid = 1'b1;
      default:                        op_valid = 1'b0;
    endcase
  end

  // Counter value N-1 marks the Nth idle cycle; a byte arriving then still wins.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= WAIT_A;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      drop_q      <= 1'b0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      drop_q      <= drop_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    frame_err_d = 1'b0;
    drop_d      = 1'b0;
    tmo_cnt_d   = '0;

    case (state_q)
      WAIT_A: begin
        if (bus.i_rx_done) begin
          alu_a_d = bus.i_rx_data;
          state_d = WAIT_B;
        end
      end

      WAIT_B: begin
        if (bus.i_rx_done) begin
          alu_b_d = bus.i_rx_data;
          state_d = WAIT_OP;
        end else if (tmo_hit) begin
          frame_err_d = 1'b1;
          state_d     = WAIT_A;
        end else if (tmo_cnt_q != TMO_MAX) begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end else begin
          tmo_cnt_d = tmo_cnt_q;
        end
      end

      WAIT_OP: begin
        if (bus.i_rx_done) begin
          if (op_valid) begin
            alu_op_d = op_field;
            state_d  = EXEC;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_A;
          end
        end else if (tmo_hit) begin
          frame_err_d = 1'b1;
          state_d     = WAIT_A;
        end else if (tmo_cnt_q != TMO_MAX) begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end else begin
          tmo_cnt_d = tmo_cnt_q;
        end
      end

      EXEC: begin
        tx_data_d  = bus.i_alu_result;
        tx_start_d = 1'b1;
        drop_d     = bus.i_rx_done;
        state_d    = WAIT_TX;
      end

      WAIT_TX: begin
        // A byte coincident with tx_done is still dropped.
        drop_d = bus.i_rx_done;
        if (bus.i_tx_done) begin
          state_d = WAIT_A;
        end
      end

      default: begin
        state_d = WAIT_A;
      end
    endcase

    busy_d = (state_d == EXEC) || (state_d == WAIT_TX);
  end

  assign bus.o_alu_op     = alu_op_q;
  assign bus.o_alu_data_A = alu_a_q;
  assign bus.o_alu_data_B = alu_b_q;
  assign bus.o_tx_data    = tx_data_q;
  assign bus.o_tx_start   = tx_start_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_frame_err  = frame_err_q;
  assign bus.o_drop       = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_uart_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_uart_ctrl
// Brief    : Directed self-checking bench for alu_uart_ctrl with an ALU model.
// Revision : 1.0
// ============================================================================
module tb_alu_uart_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   n_start;
  int   n_err;
  int   n_drop;

  alu_uart_ctrl_if #(.NB_DATA(8), .NB_OP(6)) bus ();

  alu_uart_ctrl #(
    .NB_DATA        (8),
    .NB_OP          (6),
    .TIMEOUT_CYCLES (10)
  ) u_dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU driven from the sequencer's registered operands
  always_comb begin
    case (bus.o_alu_op)
      6'b100000: bus.i_alu_result = bus.o_alu_data_A + bus.o_alu_data_B;
      6'b100010: bus.i_alu_result = bus.o_alu_data_A - bus.o_alu_data_B;
      6'b100100: bus.i_alu_result = bus.o_alu_data_A & bus.o_alu_data_B;
      6'b100101: bus.i_alu_result = bus.o_alu_data_A | bus.o_alu_data_B;
      6'b100110: bus.i_alu_result = bus.o_alu_data_A ^ bus.o_alu_data_B;
      6'b100111: bus.i_alu_result = ~(bus.o_alu_data_A | bus.o_alu_data_B);
      6'b000011: bus.i_alu_result = 8'($signed(bus.o_alu_data_A) >>> bus.o_alu_data_B);
      6'b000010: bus.i_alu_result = bus.o_alu_data_A >> bus.o_alu_data_B;
      default:   bus.i_alu_result = 8'h00;
    endcase
  end

  always @(negedge clk) begin
    if (bus.o_tx_start)  n_start++;
    if (bus.o_frame_err) n_err++;
    if (bus.o_drop)      n_drop++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
  endtask

  task automatic pulse(input logic rx, input logic tx, input logic [7:0] b);
    @(negedge clk);
    bus.i_rx_data = b;
    bus.i_rx_done = rx;
    bus.i_tx_done = tx;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
    bus.i_tx_done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] all_outs();
    return {bus.o_alu_op, bus.o_alu_data_A, bus.o_alu_data_B, bus.o_tx_data,
            bus.o_tx_start, bus.o_busy, bus.o_frame_err, bus.o_drop};
  endfunction

  // Sends a full frame, then checks the EXEC cycle and the tx_start cycle.
  task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input logic [7:0] res);
    send_byte(a);
    send_byte(b);
    send_byte(op);
    check({tag, "_exec_busy"},  32'(bus.o_busy), 32'd1);
    check({tag, "_exec_start"}, 32'(bus.o_tx_start), 32'd0);
    check({tag, "_ops"}, {8'h0, bus.o_alu_data_A, bus.o_alu_data_B, 2'b00, bus.o_alu_op},
          {8'h0, a, b, 2'b00, op[5:0]});
    @(negedge clk);
    check({tag, "_start"},   32'(bus.o_tx_start), 32'd1);
    check({tag, "_tx_data"}, 32'(bus.o_tx_data), 32'(res));
    @(negedge clk);
    check({tag, "_start_once"}, 32'(bus.o_tx_start), 32'd0);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; n_start = 0; n_err = 0; n_drop = 0;
    rst = 1'b1;
    bus.i_rx_data = '0;
    bus.i_rx_done = 1'b0;
    bus.i_tx_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_outs", all_outs(), 32'h0);

    // ADD
    run_frame("add", 8'h05, 8'h03, 8'h20, 8'h08);
    check("add_hold_busy", 32'(bus.o_busy), 32'd1);
    pulse(1'b0, 1'b1, 8'h00);
    check("add_idle", 32'(bus.o_busy), 32'd0);

    // SRA, busy held until tx_done
    run_frame("sra", 8'h80, 8'h02, 8'h03, 8'hE0);
    repeat (3) @(negedge clk);
    check("sra_busy_wait", 32'(bus.o_busy), 32'd1);
    check("sra_tx_hold", 32'(bus.o_tx_data), 32'hE0);
    pulse(1'b0, 1'b1, 8'h00);
    check("sra_idle", 32'(bus.o_busy), 32'd0);

    // Invalid opcode, then valid SUB with upper opcode bits set
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h3F);
    check("inv_err", 32'(bus.o_frame_err), 32'd1);
    check("inv_busy", 32'(bus.o_busy), 32'd0);
    check("inv_op_kept", 32'(bus.o_alu_op), 32'h03);
    check("inv_operands", {16'h0, bus.o_alu_data_A, bus.o_alu_data_B}, 32'h1122);
    @(negedge clk);
    check("inv_err_once", 32'(bus.o_frame_err), 32'd0);
    check("inv_no_start", 32'(bus.o_tx_start), 32'd0);
    run_frame("sub", 8'h0F, 8'h0A, 8'hE2, 8'h05);
    pulse(1'b0, 1'b1, 8'h00);

    // Timeout after 10 idle cycles in WAIT_B
    send_byte(8'h01);
    repeat (9) @(negedge clk);
    check("tmo_early", 32'(bus.o_frame_err), 32'd0);
    @(negedge clk);
    check("tmo_err", 32'(bus.o_frame_err), 32'd1);
    // Byte on the 10th cycle is accepted
    send_byte(8'h01);
    repeat (8) @(negedge clk);
    send_byte(8'h03);
    check("tmo_edge_noerr", 32'(bus.o_frame_err), 32'd0);
    check("tmo_edge_B", 32'(bus.o_alu_data_B), 32'h03);
    send_byte(8'h24);
    check("tmo_edge_busy", 32'(bus.o_busy), 32'd1);
    @(negedge clk);
    check("tmo_edge_tx", 32'(bus.o_tx_data), 32'h01);
    pulse(1'b0, 1'b1, 8'h00);

    // Drops while busy, including coincident with tx_done
    run_frame("or", 8'h09, 8'h04, 8'h25, 8'h0D);
    send_byte(8'h55);
    check("drop_pulse", 32'(bus.o_drop), 32'd1);
    check("drop_tx_kept", 32'(bus.o_tx_data), 32'h0D);
    check("drop_busy", 32'(bus.o_busy), 32'd1);
    pulse(1'b1, 1'b1, 8'h77);
    check("drop_coinc", 32'(bus.o_drop), 32'd1);
    check("drop_coinc_idle", 32'(bus.o_busy), 32'd0);
    run_frame("xor", 8'h06, 8'h03, 8'h26, 8'h05);
    pulse(1'b0, 1'b1, 8'h00);

    // Reset in WAIT_OP
    send_byte(8'h12);
    send_byte(8'h34);
    do_reset();
    check("rst_wop_outs", all_outs(), 32'h0);
    pulse(1'b0, 1'b1, 8'h00);
    check("rst_txdone_ign", {30'h0, bus.o_busy, bus.o_tx_start}, 32'h0);
    run_frame("nor", 8'h0C, 8'h05, 8'h27, 8'hF2);
    // Reset in WAIT_TX
    do_reset();
    check("rst_wtx_outs", all_outs(), 32'h0);
    pulse(1'b0, 1'b1, 8'h00);
    check("rst_wtx_txdone", {30'h0, bus.o_busy, bus.o_tx_start}, 32'h0);
    run_frame("srl", 8'h03, 8'h01, 8'h02, 8'h01);
    pulse(1'b0, 1'b1, 8'h00);
    @(negedge clk);

    check("total_starts", 32'(n_start), 32'd8);
    check("total_errs",   32'(n_err),   32'd2);
    check("total_drops",  32'(n_drop),  32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
